// File: rtl/mem_sram_ctrl.sv
// Memory-stage data-memory controller: one 32-bit load/store is carried out as two
// 16-bit accesses on an asynchronous SRAM, and the pipeline is stalled through Ready meanwhile.
module mem_sram_ctrl #(
  parameter int ADDR_OFFSET   = 1024,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] Address,
  input  logic [31:0] Write_Data,
  output logic [31:0] Read_Data,
  output logic        Ready,
  output logic [17:0] SRAM_ADDR,
  output logic [15:0] SRAM_DQ_Out,
  input  logic [15:0] SRAM_DQ_In,
  output logic        SRAM_DQ_OE,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
);

  localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [16:0]      word_q, word_d;
  logic [15:0]      wdata_hi_q, wdata_hi_d;
  logic             wr_q, wr_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [17:0]      addr_q, addr_d;
  logic [15:0]      dqo_q, dqo_d;

  logic        req;
  logic [31:0] eff;
  logic [16:0] req_word;
  logic        last_cyc;
  logic        busy;
  logic        unused_eff_bits;

  assign req      = MEM_R_EN | MEM_W_EN;
  assign eff      = Address - 32'(ADDR_OFFSET);
  assign req_word = eff[18:2];
  assign last_cyc = (cnt_q == CNT_LAST);
  assign unused_eff_bits = ^{eff[31:19], eff[1:0]};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
    wdata_hi_d = wdata_hi_q;
    wr_d       = wr_q;
    rdata_d    = rdata_q;
    addr_d     = addr_q;
    dqo_d      = dqo_q;
    unique case (state_q)
      S_IDLE: begin
        // Latch the whole request so later input changes cannot disturb the access.
        if (req) begin
          state_d    = S_LOW;
          cnt_d      = '0;
          word_d     = req_word;
          wdata_hi_d = Write_Data[31:16];
          wr_d       = MEM_W_EN;
          addr_d     = {req_word, 1'b0};
          dqo_d      = Write_Data[15:0];
        end
      end
      S_LOW: begin
        if (last_cyc) begin
          state_d = S_HIGH;
          cnt_d   = '0;
          addr_d  = {word_q, 1'b1};
          dqo_d   = wdata_hi_q;
          if (!wr_q) rdata_d[15:0] = SRAM_DQ_In;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HIGH: begin
        if (last_cyc) begin
          state_d = S_DONE;
          cnt_d   = '0;
          if (!wr_q) rdata_d[31:16] = SRAM_DQ_In;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Strobes decode from registered state only, so reset forces them inactive at once.
    busy        = (state_q == S_LOW) || (state_q == S_HIGH);
    SRAM_CE_N   = ~busy;
    SRAM_WE_N   = ~(busy & wr_q);
    SRAM_OE_N   = ~(busy & ~wr_q);
    SRAM_DQ_OE  = busy & wr_q;
    Ready       = ((state_q == S_IDLE) & ~req) | (state_q == S_DONE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      word_q     <= '0;
      wdata_hi_q <= '0;
      wr_q       <= 1'b0;
      rdata_q    <= '0;
      addr_q     <= '0;
      dqo_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      word_q     <= word_d;
      wdata_hi_q <= wdata_hi_d;
      wr_q       <= wr_d;
      rdata_q    <= rdata_d;
      addr_q     <= addr_d;
      dqo_q      <= dqo_d;
    end
  end

  assign Read_Data   = rdata_q;
  assign SRAM_ADDR   = addr_q;
  assign SRAM_DQ_Out = dqo_q;
  assign SRAM_UB_N   = 1'b0;
  assign SRAM_LB_N   = 1'b0;

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Self-checking bench for mem_sram_ctrl: an N=2 instance with an SRAM model and an N=1
// instance whose pad data is derived from its address; a per-cycle expectation queue drives checks.
module tb_mem_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        r_en, w_en, sel;
  logic [31:0] addr, wdata;

  logic        r0, w0, r1, w1;
  logic [31:0] rd0, rd1;
  logic        rdy0, rdy1, dqoe0, dqoe1, we0, we1, oe0, oe1, ce0, ce1, ub0, ub1, lb0, lb1;
  logic [17:0] sa0, sa1;
  logic [15:0] dqo0, dqo1, dqin0, dqin1;

  logic [15:0] mem [0:262143];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rdy, ce_n, we_n, oe_n, dq_oe;
    logic        chk_addr, chk_dq, chk_rd;
    logic [17:0] addr;
    logic [15:0] dq;
    logic [31:0] rd;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  assign r0 = r_en & ~sel;
  assign w0 = w_en & ~sel;
  assign r1 = r_en & sel;
  assign w1 = w_en & sel;

  assign dqin0 = (!oe0 && !ce0) ? mem[sa0] : 16'hA5A5;
  assign dqin1 = sa1[15:0] ^ 16'h5A5A;

  always @(posedge clk) begin
    if (!ce0 && !we0) mem[sa0] <= dqo0;
  end

  mem_sram_ctrl #(.ADDR_OFFSET(1024), .ACCESS_CYCLES(2)) dut (
    .CLK(clk), .RST(rst), .MEM_R_EN(r0), .MEM_W_EN(w0), .Address(addr), .Write_Data(wdata),
    .Read_Data(rd0), .Ready(rdy0), .SRAM_ADDR(sa0), .SRAM_DQ_Out(dqo0), .SRAM_DQ_In(dqin0),
    .SRAM_DQ_OE(dqoe0), .SRAM_WE_N(we0), .SRAM_OE_N(oe0), .SRAM_CE_N(ce0),
    .SRAM_UB_N(ub0), .SRAM_LB_N(lb0)
  );

  mem_sram_ctrl #(.ADDR_OFFSET(1024), .ACCESS_CYCLES(1)) dut1 (
    .CLK(clk), .RST(rst), .MEM_R_EN(r1), .MEM_W_EN(w1), .Address(addr), .Write_Data(wdata),
    .Read_Data(rd1), .Ready(rdy1), .SRAM_ADDR(sa1), .SRAM_DQ_Out(dqo1), .SRAM_DQ_In(dqin1),
    .SRAM_DQ_OE(dqoe1), .SRAM_WE_N(we1), .SRAM_OE_N(oe1), .SRAM_CE_N(ce1),
    .SRAM_UB_N(ub1), .SRAM_LB_N(lb1)
  );

  logic        o_rdy, o_ce, o_we, o_oe, o_dqoe;
  logic [17:0] o_sa;
  logic [15:0] o_dqo;
  logic [31:0] o_rd;

  assign o_rdy  = sel ? rdy1  : rdy0;
  assign o_ce   = sel ? ce1   : ce0;
  assign o_we   = sel ? we1   : we0;
  assign o_oe   = sel ? oe1   : oe0;
  assign o_dqoe = sel ? dqoe1 : dqoe0;
  assign o_sa   = sel ? sa1   : sa0;
  assign o_dqo  = sel ? dqo1  : dqo0;
  assign o_rd   = sel ? rd1   : rd0;

  // Drives one request starting in the current cycle (called #1 after a rising edge) and
  // walks the expected cycle-by-cycle trace; leaves req low one edge after DONE.
  task automatic run_access(input logic r, input logic w, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] exp_rd,
                            input int drop_at, input string name);
    int          n;
    logic [31:0] eff;
    logic [16:0] word;
    logic        busy, hi;
    exp_t        e;
    n    = sel ? 1 : 2;
    eff  = a - 32'd1024;
    word = eff[18:2];
    for (int k = 0; k <= 2*n+1; k++) begin
      busy       = (k >= 1) && (k <= 2*n);
      hi         = (k > n);
      e.rdy      = (k == 2*n+1);
      e.ce_n     = !busy;
      e.we_n     = !(busy && w);
      e.oe_n     = !(busy && !w);
      e.dq_oe    = busy && w;
      e.chk_addr = (k >= 1);
      e.addr     = {word, hi};
      e.chk_dq   = w && (k >= 1);
      e.dq       = hi ? wd[31:16] : wd[15:0];
      e.chk_rd   = (k == 2*n+1);
      e.rd       = exp_rd;
      exp_q.push_back(e);
    end
    r_en = r; w_en = w; addr = a; wdata = wd;
    for (int k = 0; k <= 2*n+1; k++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({o_rdy, o_ce, o_we, o_oe, o_dqoe} !== {e.rdy, e.ce_n, e.we_n, e.oe_n, e.dq_oe}) begin
        errors++;
        $display("FAIL %s c%0d rdy/ce_n/we_n/oe_n/dq_oe got %b want %b", name, k,
                 {o_rdy, o_ce, o_we, o_oe, o_dqoe}, {e.rdy, e.ce_n, e.we_n, e.oe_n, e.dq_oe});
      end
      if (e.chk_addr) begin
        checks++;
        if (o_sa !== e.addr) begin
          errors++;
          $display("FAIL %s c%0d SRAM_ADDR got %h want %h", name, k, o_sa, e.addr);
        end
      end
      if (e.chk_dq) begin
        checks++;
        if (o_dqo !== e.dq) begin
          errors++;
          $display("FAIL %s c%0d SRAM_DQ_Out got %h want %h", name, k, o_dqo, e.dq);
        end
      end
      if (e.chk_rd) begin
        checks++;
        if (o_rd !== e.rd) begin
          errors++;
          $display("FAIL %s c%0d Read_Data got %h want %h", name, k, o_rd, e.rd);
        end
      end
      @(posedge clk); #1;
      if (k == 0) begin
        addr  = $urandom;
        wdata = $urandom;
      end
      if (k + 1 == drop_at || k == 2*n+1) begin
        r_en = 1'b0; w_en = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; r_en = 1'b0; w_en = 1'b0; sel = 1'b0; addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({rdy0, ce0, we0, oe0, dqoe0, ub0, lb0} !== 7'b1111000) begin
      errors++;
      $display("FAIL reset strobes got %b want %b", {rdy0, ce0, we0, oe0, dqoe0, ub0, lb0}, 7'b1111000);
    end
    checks++;
    if ({sa0, dqo0, rd0} !== 66'd0) begin
      errors++;
      $display("FAIL reset regs got %h/%h/%h want 0", sa0, dqo0, rd0);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({rdy0, ce0, we0, oe0} !== 4'b1111) begin
        errors++;
        $display("FAIL idle_noreq c%0d rdy/ce_n/we_n/oe_n got %b want 1111", i, {rdy0, ce0, we0, oe0});
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_store;
    run_access(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 32'h0, -1, "store");
    checks++;
    if ({mem[3], mem[2]} !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL store_mem got %h want %h", {mem[3], mem[2]}, 32'hDEADBEEF);
    end
  endtask

  task automatic test_load;
    run_access(1'b1, 1'b0, 32'd1028, 32'h0, 32'hDEADBEEF, -1, "load");
  endtask

  task automatic test_back_to_back;
    run_access(1'b0, 1'b1, 32'd1032, 32'h12345678, 32'hDEADBEEF, -1, "b2b_store");
    run_access(1'b1, 1'b0, 32'd1032, 32'h0, 32'h12345678, -1, "b2b_load");
  endtask

  task automatic test_conflict_drop;
    run_access(1'b1, 1'b1, 32'd2048, 32'hCAFEF00D, 32'h12345678, -1, "conflict");
    checks++;
    if ({mem[513], mem[512]} !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL conflict_mem got %h want %h", {mem[513], mem[512]}, 32'hCAFEF00D);
    end
    run_access(1'b0, 1'b1, 32'd4096, 32'h0BADC0DE, 32'h12345678, 3, "drop");
    checks++;
    if ({mem[1537], mem[1536]} !== 32'h0BADC0DE) begin
      errors++;
      $display("FAIL drop_mem got %h want %h", {mem[1537], mem[1536]}, 32'h0BADC0DE);
    end
    @(negedge clk);
    checks++;
    if ({rdy0, ce0} !== 2'b11) begin
      errors++;
      $display("FAIL drop_idle rdy/ce_n got %b want 11", {rdy0, ce0});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    addr = 32'd1028; wdata = 32'h11112222; w_en = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (we0 !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_low we_n got %b want 0", we0);
    end
    #2 rst = 1'b1; w_en = 1'b0;
    #1;
    checks++;
    if ({we0, ce0, rdy0, rd0} !== {3'b111, 32'h0}) begin
      errors++;
      $display("FAIL rstmid_async we/ce/rdy/rd got %b%b%b/%h want 111/0", we0, ce0, rdy0, rd0);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({we0, ce0, rdy0, rd0} !== {3'b111, 32'h0}) begin
      errors++;
      $display("FAIL rstmid_next we/ce/rdy/rd got %b%b%b/%h want 111/0", we0, ce0, rdy0, rd0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_param_sweep;
    sel = 1'b1;
    run_access(1'b0, 1'b1, 32'd1020, 32'hA5A50F0F, 32'h0, -1, "n1_wrap_store");
    run_access(1'b1, 1'b0, 32'd1028, 32'h0, 32'h5A595A58, -1, "n1_load");
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_back_to_back();
    test_conflict_drop();
    test_reset_mid();
    test_param_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
